uart_cfg: RTL and testbench

Parametrised full-duplex UART with AXI-Stream byte interfaces on both directions.
- Generalises the fixed 8N1 design: configurable data width, parity and stop bits.
- RX adds a synchroniser, false-start rejection, per-frame error flags and a holding register so reception never stalls on downstream backpressure.
- Sits between a host-side AXI-Stream fabric and the board-level UART pins.

---
 rtl/uart_cfg.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_cfg.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg.sv
// -----------------------------------------------------------------------------
// uart_cfg - parametrised full-duplex UART with AXI-Stream byte interfaces.
//
// TX accepts one payload beat in IDLE, latches it, and serialises it as
// start / DATA_BITS data (LSB first) / optional parity / STOP_BITS stop bits.
// RX synchronises the serial line, rejects false starts, samples each bit at
// mid-bit, and delivers every completed frame (errors flagged in tuser) through
// a single holding register. A frame that completes while the holding register
// is full and not being read is dropped and reported on rx_overrun_o.
//
// Parameters:
//   CLK_FREQ   system clock in Hz
//   BAUD       line rate; DIV = CLK_FREQ/BAUD clocks per bit (must be >= 4)
//   DATA_BITS  payload bits per frame, 5..9
//   PARITY     0 none, 1 odd, 2 even
//   STOP_BITS  transmitted stop bits, 1 or 2 (RX checks only the first)
//
// Ports:
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   loopback_i       (only with UART_LOOPBACK_EN) RX listens to TX, pin held 1
//   s_axis_tdata_i   TX payload
//   s_axis_tvalid_i  TX payload valid
//   s_axis_tready_o  TX ready, high only while TX is idle
//   m_axis_tdata_o   RX payload
//   m_axis_tuser_o   {frame_err, parity_err} of the current RX beat
//   m_axis_tvalid_o  RX holding register full
//   m_axis_tready_i  RX consumer ready
//   uart_rx_i        serial input, asynchronous to clk_i
//   uart_tx_o        serial output, idle high
//   tx_busy_o        high while TX is not idle
//   rx_overrun_o     one-cycle pulse when a completed frame is dropped
//
// Optional feature macro: UART_LOOPBACK_EN (adds loopback_i).
// -----------------------------------------------------------------------------
module uart_cfg #(
    parameter int CLK_FREQ  = 1152000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback_i,
`endif
    input  logic [DATA_BITS-1:0] s_axis_tdata_i,
    input  logic                 s_axis_tvalid_i,
    output logic                 s_axis_tready_o,
    output logic [DATA_BITS-1:0] m_axis_tdata_o,
    output logic [1:0]           m_axis_tuser_o,
    output logic                 m_axis_tvalid_o,
    input  logic                 m_axis_tready_i,
    input  logic                 uart_rx_i,
    output logic                 uart_tx_o,
    output logic                 tx_busy_o,
    output logic                 rx_overrun_o
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam bit            PAR_EN    = (PARITY != 0);
    localparam bit            PAR_ODD   = (PARITY == 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (DIV < 4) begin : g_bad_div
            $error("uart_cfg: CLK_FREQ/BAUD must be at least 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_cfg: DATA_BITS must be in 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    // Parity bit that accompanies a payload: even parity makes the total
    // number of ones even, odd parity is its inverse.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return PAR_ODD ? ~(^d) : (^d);
    endfunction

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    state_e               r_tx_state,  w_tx_state_nx;
    logic [CW-1:0]        r_tx_cnt,    w_tx_cnt_nx;
    logic [3:0]           r_tx_idx,    w_tx_idx_nx;
    logic [DATA_BITS-1:0] r_tx_shift,  w_tx_shift_nx;
    logic                 r_tx_par,    w_tx_par_nx;
    logic                 r_tx_line,   w_tx_line_nx;
    logic                 w_tx_tick;

    assign w_tx_tick = (r_tx_cnt == BIT_LAST);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = (r_tx_state == ST_IDLE || w_tx_tick) ? '0 : r_tx_cnt + CW'(1);
        w_tx_idx_nx   = r_tx_idx;
        w_tx_shift_nx = r_tx_shift;
        w_tx_par_nx   = r_tx_par;
        w_tx_line_nx  = 1'b1;

        case (r_tx_state)
            ST_IDLE: begin
                // tready is high in IDLE, so tvalid alone completes the handshake.
                if (s_axis_tvalid_i) begin
                    w_tx_state_nx = ST_START;
                    w_tx_shift_nx = s_axis_tdata_i;
                    w_tx_par_nx   = parity_of(s_axis_tdata_i);
                    w_tx_idx_nx   = '0;
                end
            end
            ST_START: begin
                if (w_tx_tick) begin
                    w_tx_state_nx = ST_DATA;
                    w_tx_idx_nx   = '0;
                end
            end
            ST_DATA: begin
                if (w_tx_tick) begin
                    if (r_tx_idx == DATA_LAST) begin
                        w_tx_state_nx = PAR_EN ? ST_PARITY : ST_STOP;
                        w_tx_idx_nx   = '0;
                    end else begin
                        w_tx_idx_nx   = r_tx_idx + 4'd1;
                        w_tx_shift_nx = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                    end
                end
            end
            ST_PARITY: begin
                if (w_tx_tick) begin
                    w_tx_state_nx = ST_STOP;
                    w_tx_idx_nx   = '0;
                end
            end
            ST_STOP: begin
                if (w_tx_tick) begin
                    if (r_tx_idx == STOP_LAST) begin
                        w_tx_state_nx = ST_IDLE;
                    end else begin
                        w_tx_idx_nx = r_tx_idx + 4'd1;
                    end
                end
            end
            default: w_tx_state_nx = ST_IDLE;
        endcase

        // The line level is registered from the next state so the pin is
        // glitch-free and falls in the first START cycle.
        case (w_tx_state_nx)
            ST_START:  w_tx_line_nx = 1'b0;
            ST_DATA:   w_tx_line_nx = w_tx_shift_nx[0];
            ST_PARITY: w_tx_line_nx = w_tx_par_nx;
            default:   w_tx_line_nx = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all next
    // values are computed combinationally above.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_idx   <= w_tx_idx_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_tx_par   <= w_tx_par_nx;
            r_tx_line  <= w_tx_line_nx;
        end
    end

    assign s_axis_tready_o = (r_tx_state == ST_IDLE);
    assign tx_busy_o       = (r_tx_state != ST_IDLE);

    // ------------------------------------------------------------------
    // Loopback selection
    // ------------------------------------------------------------------
    logic w_rx_src;

`ifdef UART_LOOPBACK_EN
    assign w_rx_src  = loopback_i ? r_tx_line : uart_rx_i;
    assign uart_tx_o = loopback_i ? 1'b1 : r_tx_line;
`else
    assign w_rx_src  = uart_rx_i;
    assign uart_tx_o = r_tx_line;
`endif

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic                 r_rx_sync1, r_rx_sync2;
    logic                 w_rx;
    state_e               r_rx_state,   w_rx_state_nx;
    logic [CW-1:0]        r_rx_cnt,     w_rx_cnt_nx;
    logic [3:0]           r_rx_idx,     w_rx_idx_nx;
    logic [DATA_BITS-1:0] r_rx_shift,   w_rx_shift_nx;
    logic                 r_rx_par_bit, w_rx_par_bit_nx;
    logic                 w_rx_done;

    logic [DATA_BITS-1:0] r_m_data,  w_m_data_nx;
    logic [1:0]           r_m_user,  w_m_user_nx;
    logic                 r_m_valid, w_m_valid_nx;
    logic                 r_ovr,     w_ovr_nx;
    logic                 w_m_load;
    logic                 w_frame_err, w_par_err;

    assign w_rx = r_rx_sync2;

    always_comb begin
        w_rx_state_nx   = r_rx_state;
        w_rx_cnt_nx     = r_rx_cnt + CW'(1);
        w_rx_idx_nx     = r_rx_idx;
        w_rx_shift_nx   = r_rx_shift;
        w_rx_par_bit_nx = r_rx_par_bit;
        w_rx_done       = 1'b0;

        case (r_rx_state)
            ST_IDLE: begin
                w_rx_cnt_nx = '0;
                if (!w_rx) begin
                    w_rx_state_nx = ST_START;
                end
            end
            ST_START: begin
                // Half a bit after the falling edge: a high sample here means
                // the low level was a glitch, not a start bit.
                if (r_rx_cnt == HALF_LAST) begin
                    w_rx_cnt_nx = '0;
                    w_rx_idx_nx = '0;
                    w_rx_state_nx = w_rx ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_shift_nx = {w_rx, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_idx == DATA_LAST) begin
                        w_rx_state_nx = PAR_EN ? ST_PARITY : ST_STOP;
                        w_rx_idx_nx   = '0;
                    end else begin
                        w_rx_idx_nx = r_rx_idx + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_nx     = '0;
                    w_rx_par_bit_nx = w_rx;
                    w_rx_state_nx   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_done     = 1'b1;
                    w_rx_state_nx = ST_IDLE;
                end
            end
            default: w_rx_state_nx = ST_IDLE;
        endcase
    end

    assign w_frame_err = ~w_rx;
    assign w_par_err   = PAR_EN && (r_rx_par_bit != parity_of(r_rx_shift));

    // A completed frame may replace the held beat only if that beat is
    // leaving in the same cycle; otherwise the new frame is dropped.
    assign w_m_load = w_rx_done && (!r_m_valid || m_axis_tready_i);

    always_comb begin
        w_m_data_nx  = r_m_data;
        w_m_user_nx  = r_m_user;
        w_m_valid_nx = r_m_valid;
        if (w_m_load) begin
            w_m_data_nx  = r_rx_shift;
            w_m_user_nx  = {w_frame_err, w_par_err};
            w_m_valid_nx = 1'b1;
        end else if (r_m_valid && m_axis_tready_i) begin
            w_m_valid_nx = 1'b0;
        end
        w_ovr_nx = w_rx_done && !w_m_load;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_sync1   <= 1'b1;
            r_rx_sync2   <= 1'b1;
            r_rx_state   <= ST_IDLE;
            r_rx_cnt     <= '0;
            r_rx_idx     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_bit <= 1'b0;
            r_m_data     <= '0;
            r_m_user     <= '0;
            r_m_valid    <= 1'b0;
            r_ovr        <= 1'b0;
        end else begin
            r_rx_sync1   <= w_rx_src;
            r_rx_sync2   <= r_rx_sync1;
            r_rx_state   <= w_rx_state_nx;
            r_rx_cnt     <= w_rx_cnt_nx;
            r_rx_idx     <= w_rx_idx_nx;
            r_rx_shift   <= w_rx_shift_nx;
            r_rx_par_bit <= w_rx_par_bit_nx;
            r_m_data     <= w_m_data_nx;
            r_m_user     <= w_m_user_nx;
            r_m_valid    <= w_m_valid_nx;
            r_ovr        <= w_ovr_nx;
        end
    end

    assign m_axis_tdata_o  = r_m_data;
    assign m_axis_tuser_o  = r_m_user;
    assign m_axis_tvalid_o = r_m_valid;
    assign rx_overrun_o    = r_ovr;

endmodule

// File: tb/tb_uart_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_cfg - self-checking bench for uart_cfg.
//
// Main instance (defaults, DIV=10): a per-cycle compare process checks the TX
// pin, tready and busy against a queue of expected line levels built from the
// frame definition, and checks every RX beat against a queue of expected
// {data, flags}, plus hold stability and overrun pulse width.
// Two extra instances (odd and even parity) are cross-wired so each receives
// the other's frame, exercising the parity generator and the parity checker.
// -----------------------------------------------------------------------------
module tb_uart_cfg;

    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic [1:0] m_tuser;
    logic       m_tvalid;
    logic       m_tready = 1'b0;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    logic       tx_busy;
    logic       rx_ovr;

    // Parity instances
    logic [7:0] p_tdata = '0;
    logic       p_tvalid = 1'b0;
    logic       p_m_tready = 1'b0;
    logic       p1_tready, p2_tready;
    logic [7:0] p1_m_tdata, p2_m_tdata;
    logic [1:0] p1_m_tuser, p2_m_tuser;
    logic       p1_m_tvalid, p2_m_tvalid;
    logic       p1_tx, p2_tx;
    logic       p1_busy, p2_busy;
    logic       p1_ovr, p2_ovr;

    uart_cfg u_dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
`ifdef UART_LOOPBACK_EN
        .loopback_i      (1'b0),
`endif
        .s_axis_tdata_i  (s_tdata),
        .s_axis_tvalid_i (s_tvalid),
        .s_axis_tready_o (s_tready),
        .m_axis_tdata_o  (m_tdata),
        .m_axis_tuser_o  (m_tuser),
        .m_axis_tvalid_o (m_tvalid),
        .m_axis_tready_i (m_tready),
        .uart_rx_i       (uart_rx),
        .uart_tx_o       (uart_tx),
        .tx_busy_o       (tx_busy),
        .rx_overrun_o    (rx_ovr)
    );

    uart_cfg #(.PARITY(1)) u_odd (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
`ifdef UART_LOOPBACK_EN
        .loopback_i      (1'b0),
`endif
        .s_axis_tdata_i  (p_tdata),
        .s_axis_tvalid_i (p_tvalid),
        .s_axis_tready_o (p1_tready),
        .m_axis_tdata_o  (p1_m_tdata),
        .m_axis_tuser_o  (p1_m_tuser),
        .m_axis_tvalid_o (p1_m_tvalid),
        .m_axis_tready_i (p_m_tready),
        .uart_rx_i       (p2_tx),
        .uart_tx_o       (p1_tx),
        .tx_busy_o       (p1_busy),
        .rx_overrun_o    (p1_ovr)
    );

    uart_cfg #(.PARITY(2)) u_even (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
`ifdef UART_LOOPBACK_EN
        .loopback_i      (1'b0),
`endif
        .s_axis_tdata_i  (p_tdata),
        .s_axis_tvalid_i (p_tvalid),
        .s_axis_tready_o (p2_tready),
        .m_axis_tdata_o  (p2_m_tdata),
        .m_axis_tuser_o  (p2_m_tuser),
        .m_axis_tvalid_o (p2_m_tvalid),
        .m_axis_tready_i (p_m_tready),
        .uart_rx_i       (p1_tx),
        .uart_tx_o       (p2_tx),
        .tx_busy_o       (p2_busy),
        .rx_overrun_o    (p2_ovr)
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    logic       tx_q[$];   // expected uart_tx level, one entry per clock
    logic [9:0] rx_q[$];   // expected RX beats {data, frame_err, parity_err}
    int         exp_ovr  = 0;
    int         ovr_seen = 0;

    // Per-cycle compare of the main instance, away from the active edge.
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    logic [1:0] prev_user = '0;
    logic       prev_ovr  = 1'b0;

    always @(negedge clk) begin : cmp
        logic       exp_line;
        logic       exp_busy;
        logic [9:0] beat;
        if (tx_q.size() != 0) begin
            exp_line = tx_q.pop_front();
            exp_busy = 1'b1;
        end else begin
            exp_line = 1'b1;
            exp_busy = 1'b0;
        end
        check("tx_line",   32'(uart_tx),  32'(exp_line));
        check("tx_tready", 32'(s_tready), 32'(!exp_busy));
        check("tx_busy",   32'(tx_busy),  32'(exp_busy));

        if (!rst_ni) begin
            check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
            check("rst_m_tdata",  32'(m_tdata),  32'd0);
            check("rst_m_tuser",  32'(m_tuser),  32'd0);
            check("rst_rx_ovr",   32'(rx_ovr),   32'd0);
            prev_hold = 1'b0;
            prev_ovr  = 1'b0;
        end else begin
            if (prev_hold) begin
                check("rx_hold_valid", 32'(m_tvalid), 32'd1);
                check("rx_hold_data",  32'(m_tdata),  32'(prev_data));
                check("rx_hold_user",  32'(m_tuser),  32'(prev_user));
            end
            if (m_tvalid && m_tready) begin
                check("rx_beat_expected", 32'(rx_q.size() != 0), 32'd1);
                if (rx_q.size() != 0) begin
                    beat = rx_q.pop_front();
                    check("rx_beat_data", 32'(m_tdata), 32'(beat[9:2]));
                    check("rx_beat_user", 32'(m_tuser), 32'(beat[1:0]));
                end
            end
            if (rx_ovr) begin
                ovr_seen++;
                check("rx_ovr_one_cycle", 32'(prev_ovr), 32'd0);
            end
            prev_hold = m_tvalid && !m_tready;
            prev_data = m_tdata;
            prev_user = m_tuser;
            prev_ovr  = rx_ovr;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change #1 after the rising edge)
    // ------------------------------------------------------------------
    task automatic tx_send(input logic [7:0] d);
        int         waited;
        logic [9:0] fr;
        waited = 0;
        while (tx_q.size() != 0 && waited < 1000) begin
            @(posedge clk); #1;
            waited++;
        end
        check("tx_idle_wait", 32'(waited < 1000), 32'd1);
        s_tdata  = d;
        s_tvalid = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tdata  = ~d;          // must not disturb the frame in flight
        fr = {1'b1, d, 1'b0};   // stop, data LSB first, start
        for (int b = 0; b < 10; b++)
            repeat (DIV) tx_q.push_back(fr[b]);
    endtask

    // Samples the main TX pin mid-bit for one frame and counts busy cycles.
    task automatic tx_capture(output logic [9:0] bits, output int low_rdy, output int busy);
        bits    = '0;
        low_rdy = 0;
        busy    = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (k < 100 && (k % DIV) == DIV / 2) bits[k / DIV] = uart_tx;
            if (!s_tready) low_rdy++;
            if (tx_busy) busy++;
        end
    endtask

    task automatic rx_bit(input logic v);
        uart_rx = v;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic rx_send(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        if (rx_q.size() == 0 || m_tready) rx_q.push_back({d, ~stop, 1'b0});
        else exp_ovr++;
        fr = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) rx_bit(fr[b]);
        rx_bit(1'b1);
        rx_bit(1'b1);
    endtask

    task automatic pulse_m_ready;
        m_tready = 1'b1;
        @(posedge clk); #1;
        m_tready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : seq
        logic [9:0] bits;
        int         low_rdy, busy;
        logic       par_odd, par_even;
        int         busy_odd, busy_even;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_tx",  32'(uart_tx),     32'd1);
        check("rst_tready",   32'(s_tready),    32'd1);
        check("rst_busy",     32'(tx_busy),     32'd0);
        check("rst_p_tvalid", 32'(p1_m_tvalid), 32'd0);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // TX 0xA5: 0,1,0,1,0,0,1,0,1,1 (bit 0 first), 100 cycles busy
        tx_send(8'hA5);
        tx_capture(bits, low_rdy, busy);
        check("tx_a5_bits",    32'(bits),    32'b1101001010);
        check("tx_a5_tready0", 32'(low_rdy), 32'd100);
        check("tx_a5_busy",    32'(busy),    32'd100);

        // Parity instances send 0x07 to each other
        p_tdata  = 8'h07;
        p_tvalid = 1'b1;
        @(posedge clk); #1;
        p_tvalid  = 1'b0;
        p_tdata   = 8'h00;
        par_odd   = 1'bx;
        par_even  = 1'bx;
        busy_odd  = 0;
        busy_even = 0;
        for (int k = 0; k < 130; k++) begin
            @(negedge clk);
            if (k == 9 * DIV + DIV / 2) begin
                par_odd  = p1_tx;
                par_even = p2_tx;
            end
            if (p1_busy) busy_odd++;
            if (p2_busy) busy_even++;
        end
        check("par_even_bit",   32'(par_even),  32'd1);
        check("par_odd_bit",    32'(par_odd),   32'd0);
        check("par_even_len",   32'(busy_even), 32'd110);
        check("par_odd_len",    32'(busy_odd),  32'd110);
        // Each side sees the other's parity convention, so both flag parity_err.
        check("par_odd_rx_v",   32'(p1_m_tvalid), 32'd1);
        check("par_odd_rx_d",   32'(p1_m_tdata),  32'h07);
        check("par_odd_rx_u",   32'(p1_m_tuser),  32'b01);
        check("par_even_rx_v",  32'(p2_m_tvalid), 32'd1);
        check("par_even_rx_d",  32'(p2_m_tdata),  32'h07);
        check("par_even_rx_u",  32'(p2_m_tuser),  32'b01);
        check("par_no_ovr",     32'(p1_ovr | p2_ovr), 32'd0);
        check("par_tready_back", 32'(p1_tready & p2_tready), 32'd1);
        p_m_tready = 1'b1;
        @(posedge clk); #1;
        p_m_tready = 1'b0;
        check("par_rx_consumed", 32'(p1_m_tvalid | p2_m_tvalid), 32'd0);

        // RX 0x3C with stop bit 0: delivered with frame_err, held until ready
        m_tready = 1'b0;
        rx_send(8'h3C, 1'b0);
        check("rx_3c_valid", 32'(m_tvalid), 32'd1);
        check("rx_3c_data",  32'(m_tdata),  32'h3C);
        check("rx_3c_user",  32'(m_tuser),  32'b10);
        repeat (5) @(posedge clk);
        #1;
        pulse_m_ready();
        check("rx_3c_gone",  32'(m_tvalid), 32'd0);
        check("rx_3c_no_ovr", 32'(ovr_seen), 32'd0);

        // Overrun: 0x11 held, 0x22 dropped
        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        check("ovr_hold_data", 32'(m_tdata),  32'h11);
        check("ovr_hold_user", 32'(m_tuser),  32'b00);
        check("ovr_count",     32'(ovr_seen), 32'd1);
        pulse_m_ready();
        repeat (30) @(posedge clk);
        #1;
        check("ovr_no_second", 32'(m_tvalid), 32'd0);

        // 3-cycle glitch is rejected, next frame is received
        uart_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (3 * DIV) @(posedge clk);
        #1;
        check("glitch_no_valid", 32'(m_tvalid), 32'd0);
        rx_send(8'h5A, 1'b1);
        check("rx_5a_valid", 32'(m_tvalid), 32'd1);
        check("rx_5a_data",  32'(m_tdata),  32'h5A);
        check("rx_5a_user",  32'(m_tuser),  32'b00);
        pulse_m_ready();
        check("rx_q_drained", 32'(rx_q.size()), 32'd0);

        // Reset during TX data bit 3 aborts at once
        tx_send(8'h3C);
        repeat (4 * DIV + 3) @(posedge clk);
        #1;
        rst_ni = 1'b0;
        tx_q.delete();
        #1;
        check("midrst_tx",     32'(uart_tx),  32'd1);
        check("midrst_tready", 32'(s_tready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        tx_send(8'h81);
        tx_capture(bits, low_rdy, busy);
        check("tx_81_bits",    32'(bits),    32'b1100000010);
        check("tx_81_tready0", 32'(low_rdy), 32'd100);

        check("final_ovr_model", 32'(ovr_seen), 32'(exp_ovr));
        check("final_rx_q",      32'(rx_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1, "timeout");
    end

endmodule
